cdc_xfer_scheduler: RTL and testbench
=====================================

Name: cdc_xfer_scheduler

Overview:
- Single-clock (AHB domain) scheduler that shares one toggle-based pulse-synchronizer channel toward mem_clk between N_REQ requesters: read-sequence change, write-sequence change, JHR enable and status-read data ack.
- Latches request pulses, grants them round-robin, launches one toggle at a time and waits for the returned, already double-flopped ack toggle.
- Reports per-requester completion and flags a sticky timeout if the far side never acknowledges.

Parameters:
- N_REQ, 4, number of requesters.
- SEL_W, 2, width of xfer_sel; must satisfy 2**SEL_W >= N_REQ.
- TMO_CYC, 64, ahb_clk cycles allowed in WAIT_ACK before timeout; must be >= 4.
- TMO_W, 7, timeout counter width; must satisfy 2**TMO_W > TMO_CYC.
- GAP_CYC, 2, idle cycles enforced between completion and the next launch; 0 is allowed.

Ports:
- ahb_clk  in  1  sole clock; all logic is rising-edge.
- ahb_rst_n  in  1  asynchronous, active-low reset.
- req_pulse  in  N_REQ  one-cycle request strobes, one bit per requester.
- err_clr  in  1  clears timeout_err and re-aligns the channel.
- ack_toggle_sync  in  1  far-side ack toggle, already synchronized into ahb_clk.
- xfer_toggle  out  1  launch toggle toward the synchronizer.
- xfer_sel  out  SEL_W  index of the in-flight requester; stable while in WAIT_ACK.
- req_pend  out  N_REQ  latched pending requests.
- done_pulse  out  N_REQ  one-cycle completion strobe per requester.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky timeout flag.
- err_sel  out  SEL_W  index of the requester that timed out.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, counters 0. Reset mid-transfer drops the in-flight transfer and all pending requests.
- Pending latch: req_pend[i] is set the cycle after req_pulse[i] and cleared together with done_pulse[i].
  - If set and clear coincide, set wins; the request is re-queued.
  - A pulse on a request that is already pending coalesces into it and is not counted twice.
- States: IDLE, WAIT_ACK, GAP, ERR.
- IDLE:
  - If any req_pend bit is set, the round-robin arbiter picks the first pending index at or after the pointer, wrapping at N_REQ.
  - On that edge, xfer_sel takes the index, xfer_toggle inverts, the timeout counter clears and the state moves to WAIT_ACK.
  - Latency: req_pulse in cycle t gives req_pend in t+1 and the xfer_toggle flip in t+2.
  - xfer_sel and xfer_toggle change on the same edge. The destination samples xfer_sel only after the toggle has crossed its synchronizer, so this is safe.
- WAIT_ACK:
  - Ack condition: ack_toggle_sync equals xfer_toggle.
  - When the ack condition holds, done_pulse[xfer_sel] is high for exactly one cycle, req_pend[xfer_sel] clears and the pointer moves to xfer_sel+1 (mod N_REQ).
  - After an ack the state goes to GAP, or straight to IDLE when GAP_CYC is 0.
  - Otherwise the counter increments. At TMO_CYC-1 with no ack: state goes to ERR, timeout_err is set to 1, err_sel takes xfer_sel, and no done_pulse is issued. That req_pend bit stays set.
- GAP: counts GAP_CYC cycles, then returns to IDLE. New requests keep latching during GAP.
- ERR:
  - No launches take place; requests keep latching.
  - err_clr causes timeout_err to clear, xfer_toggle to load ack_toggle_sync (re-align) and the state to return to IDLE.
  - A late ack that arrives in ERR is ignored.
  - If err_clr is held in any other state, it has no effect.
- Invariants:
  - At most one transfer is in flight.
  - done_pulse is one-hot or zero.
  - xfer_toggle changes only on the IDLE→WAIT_ACK edge or on the err_clr re-align.

Decomposition:
- Shared package cdc_sched_pkg: state enum (IDLE=2'd0, WAIT_ACK=2'd1, GAP=2'd2, ERR=2'd3) and default TMO_CYC/GAP_CYC constants.
- One sub-module, rr_arbiter: N_REQ-wide round-robin priority pick with pointer input, producing a valid flag and an encoded index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Single request: req_pulse=4'b0100 at t; far-side model echoes the toggle 4 cycles after it flips. Expect xfer_sel=2 and xfer_toggle flipping at t+2, then done_pulse=4'b0100 for exactly one cycle, then busy low after 2 GAP cycles.
- Fairness: req_pulse=4'b1111 in a single cycle. Expect grants in order 0,1,2,3, four done_pulses, and xfer_toggle flipping 4 times in total.
- Rotation: after grant 1 completes, pulse req 0 and req 3 together. Expect 3 to be granted before 0.
- Timeout: req 1 with no ack. Expect state ERR and timeout_err=1 at 64 cycles after launch, err_sel=1, no done_pulse, req_pend[1] still set. Then err_clr: xfer_toggle equals ack_toggle_sync and req 1 is relaunched.
- Set/clear collision: re-pulse req 2 in the same cycle as its done_pulse. Expect req_pend[2]=1 the next cycle and a second transfer.
- Reset mid WAIT_ACK: deassert ahb_rst_n. All outputs go to 0 immediately; after release, state is IDLE and nothing is pending.

Source files
------------

// File: rtl/cdc_sched_pkg.sv
// Shared types and defaults for the CDC transfer scheduler.
// Combinational definitions only; no latency.
// No flow control here; consumers own all handshaking.
package cdc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2,
        ERR      = 2'd3
    } sched_state_e;

    localparam int DEF_TMO_CYC = 64;
    localparam int DEF_GAP_CYC = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping at N_REQ.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the grant is consumed.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [SEL_W-1:0] idx_o
);

    // Scan from the farthest offset down so the nearest pending index wins last.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
                vld_o = 1'b1;
                idx_o = SEL_W'((int'(ptr_i) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// Shares one toggle pulse-synchronizer channel between N_REQ requesters, round-robin.
// req_pulse at t -> req_pend at t+1 -> xfer_toggle flip at t+2; done when ack toggle matches.
// One transfer in flight; requests keep latching while busy, GAP or ERR.
module cdc_xfer_scheduler
    import cdc_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SEL_W   = 2,
    parameter int TMO_CYC = DEF_TMO_CYC,
    parameter int TMO_W   = 7,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic             ahb_clk,
    input  logic             ahb_rst_n,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             err_clr,
    input  logic             ack_toggle_sync,
    output logic             xfer_toggle,
    output logic [SEL_W-1:0] xfer_sel,
    output logic [N_REQ-1:0] req_pend,
    output logic [N_REQ-1:0] done_pulse,
    output logic             busy,
    output logic             timeout_err,
    output logic [SEL_W-1:0] err_sel
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0] GAP_LAST = (GAP_CYC > 0) ? TMO_W'(GAP_CYC - 1) : '0;

    sched_state_e     state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] err_sel_q, err_sel_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tog_q, tog_d;
    logic             terr_q, terr_d;
    logic [N_REQ-1:0] done;
    logic             arb_vld;
    logic [SEL_W-1:0] arb_idx;
    logic             ack_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i (pend_q),
        .ptr_i (ptr_q),
        .vld_o (arb_vld),
        .idx_o (arb_idx)
    );

    assign ack_hit = (ack_toggle_sync == tog_q);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        err_sel_d = err_sel_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        terr_d    = terr_q;
        done      = '0;

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    sel_d   = arb_idx;
                    tog_d   = ~tog_q;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_hit) begin
                    done[sel_q] = 1'b1;
                    ptr_d       = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + SEL_W'(1);
                    cnt_d       = '0;
                    state_d     = (GAP_CYC == 0) ? IDLE : GAP;
                end else if (cnt_q == TMO_LAST) begin
                    terr_d    = 1'b1;
                    err_sel_d = sel_q;
                    state_d   = ERR;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ERR: begin
                // Re-align so the next launch starts from a matched toggle pair.
                if (err_clr) begin
                    terr_d  = 1'b0;
                    tog_d   = ack_toggle_sync;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new pulse in the completion cycle re-queues the request.
        pend_d = (pend_q & ~done) | req_pulse;
    end

    always_ff @(posedge ahb_clk or negedge ahb_rst_n) begin
        if (!ahb_rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            err_sel_q <= '0;
            cnt_q     <= '0;
            tog_q     <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            err_sel_q <= err_sel_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            terr_q    <= terr_d;
        end
    end

    assign xfer_toggle = tog_q;
    assign xfer_sel    = sel_q;
    assign req_pend    = pend_q;
    assign done_pulse  = done;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign err_sel     = err_sel_q;

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// Bench for cdc_xfer_scheduler: far-side echo model plus a completion scoreboard.
module tb_cdc_xfer_scheduler;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    logic             ahb_clk = 1'b0;
    logic             ahb_rst_n;
    logic [N_REQ-1:0] req_pulse;
    logic             err_clr;
    logic             ack_toggle_sync;
    logic             xfer_toggle;
    logic [SEL_W-1:0] xfer_sel;
    logic [N_REQ-1:0] req_pend;
    logic [N_REQ-1:0] done_pulse;
    logic             busy;
    logic             timeout_err;
    logic [SEL_W-1:0] err_sel;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int flips = 0;
    logic prev_tog = 1'b0;
    logic ack_en;
    logic [2:0] echo_pipe;
    logic [N_REQ-1:0] exp_q[$];
    logic [N_REQ-1:0] exp_dp;

    always #5 ahb_clk = ~ahb_clk;

    cdc_xfer_scheduler dut (
        .ahb_clk         (ahb_clk),
        .ahb_rst_n       (ahb_rst_n),
        .req_pulse       (req_pulse),
        .err_clr         (err_clr),
        .ack_toggle_sync (ack_toggle_sync),
        .xfer_toggle     (xfer_toggle),
        .xfer_sel        (xfer_sel),
        .req_pend        (req_pend),
        .done_pulse      (done_pulse),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .err_sel         (err_sel)
    );

    // Far side: the launch toggle reappears on ack_toggle_sync 4 cycles after it flips.
    always @(posedge ahb_clk or negedge ahb_rst_n) begin
        if (!ahb_rst_n) begin
            echo_pipe       <= '0;
            ack_toggle_sync <= 1'b0;
        end else if (ack_en) begin
            echo_pipe       <= {echo_pipe[1:0], xfer_toggle};
            ack_toggle_sync <= echo_pipe[2];
        end
    end

    // Scoreboard: every completion must match the next expected one-hot.
    always @(negedge ahb_clk) begin
        if (xfer_toggle !== prev_tog) flips++;
        prev_tog = xfer_toggle;
        if (done_pulse !== '0) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got=%b expected=none", done_pulse);
            end else begin
                exp_dp = exp_q.pop_front();
                if (done_pulse !== exp_dp) begin
                    errors++;
                    $display("FAIL done_order got=%b expected=%b", done_pulse, exp_dp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ahb_clk);
        #1;
    endtask

    task automatic pulse(input logic [N_REQ-1:0] v);
        req_pulse = v;
        tick();
        req_pulse = '0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy || req_pend != '0) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (busy || req_pend != '0) begin
            errors++;
            $display("FAIL wait_idle busy=%b pend=%b required idle within %0d cycles", busy, req_pend, max_cyc);
        end
    endtask

    task automatic test_reset();
        ahb_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({xfer_toggle, xfer_sel, req_pend, done_pulse, busy, timeout_err, err_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0",
                     {xfer_toggle, xfer_sel, req_pend, done_pulse, busy, timeout_err, err_sel});
        end
        ahb_rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || req_pend !== '0) begin
            errors++;
            $display("FAIL reset_release busy=%b pend=%b required 0/0", busy, req_pend);
        end
    endtask

    task automatic test_fairness();
        int f0 = flips;
        int d0 = done_cnt;
        for (int i = 0; i < N_REQ; i++) exp_q.push_back(N_REQ'(1) << i);
        pulse(4'b1111);
        checks++;
        if (req_pend !== 4'b1111) begin
            errors++;
            $display("FAIL fair_pend got=%b required=1111", req_pend);
        end
        tick();
        checks++;
        if (xfer_sel !== 2'd0) begin
            errors++;
            $display("FAIL fair_first_sel got=%0d required=0", xfer_sel);
        end
        wait_idle(200);
        checks++;
        if (done_cnt - d0 != 4 || flips - f0 != 4) begin
            errors++;
            $display("FAIL fair_counts done=%0d flips=%0d required 4/4", done_cnt - d0, flips - f0);
        end
    endtask

    task automatic test_rotation();
        exp_q.push_back(4'b0010);
        pulse(4'b0010);
        wait_idle(50);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        pulse(4'b1001);
        tick();
        checks++;
        if (xfer_sel !== 2'd3) begin
            errors++;
            $display("FAIL rot_sel got=%0d required=3", xfer_sel);
        end
        wait_idle(100);
    endtask

    task automatic test_single();
        logic tog0;
        int n = 0;
        tog0 = xfer_toggle;
        exp_q.push_back(4'b0100);
        pulse(4'b0100);
        checks++;
        if (req_pend !== 4'b0100 || xfer_toggle !== tog0) begin
            errors++;
            $display("FAIL single_pend pend=%b tog=%b required 0100/%b", req_pend, xfer_toggle, tog0);
        end
        tick();
        checks++;
        if (xfer_sel !== 2'd2 || xfer_toggle !== ~tog0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_launch sel=%0d tog=%b busy=%b required 2/%b/1", xfer_sel, xfer_toggle, busy, ~tog0);
        end
        while (done_pulse == '0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL single_ack_latency got=%0d required=4", n);
        end
        tick();
        checks++;
        if (done_pulse !== '0 || busy !== 1'b1 || req_pend !== '0) begin
            errors++;
            $display("FAIL single_gap1 done=%b busy=%b pend=%b required 0000/1/0000", done_pulse, busy, req_pend);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap2 busy=%b required=1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b required=0", busy);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        int d0 = done_cnt;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        pulse(4'b0100);
        while (done_pulse[2] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        pulse(4'b0100);
        checks++;
        if (req_pend[2] !== 1'b1) begin
            errors++;
            $display("FAIL collide_requeue got=%b required=1", req_pend[2]);
        end
        wait_idle(50);
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL collide_count got=%0d required=2", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        logic tog_l;
        int d0 = done_cnt;
        ack_en = 1'b0;
        pulse(4'b0010);
        tick();
        tog_l = xfer_toggle;
        repeat (63) tick();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early terr=%b busy=%b required 0/1", timeout_err, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || err_sel !== 2'd1 || req_pend[1] !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL tmo_flag terr=%b esel=%0d pend1=%b dones=%0d required 1/1/1/0",
                     timeout_err, err_sel, req_pend[1], done_cnt - d0);
        end
        repeat (3) tick();
        checks++;
        if (xfer_toggle !== tog_l || busy !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_hold tog=%b busy=%b terr=%b required %b/1/1", xfer_toggle, busy, timeout_err, tog_l);
        end
        exp_q.push_back(4'b0010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || xfer_toggle !== ack_toggle_sync || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear terr=%b tog=%b ack=%b busy=%b required 0/equal/0",
                     timeout_err, xfer_toggle, ack_toggle_sync, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || xfer_sel !== 2'd1 || xfer_toggle === ack_toggle_sync) begin
            errors++;
            $display("FAIL tmo_relaunch busy=%b sel=%0d tog=%b required 1/1/flipped", busy, xfer_sel, xfer_toggle);
        end
        ack_en = 1'b1;
        wait_idle(50);
    endtask

    task automatic test_reset_mid();
        pulse(4'b0001);
        tick();
        pulse(4'b0100);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got=%b required=1", busy);
        end
        ahb_rst_n = 1'b0;
        #1;
        checks++;
        if ({xfer_toggle, xfer_sel, req_pend, done_pulse, busy, timeout_err, err_sel} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%b required=0",
                     {xfer_toggle, xfer_sel, req_pend, done_pulse, busy, timeout_err, err_sel});
        end
        repeat (2) tick();
        ahb_rst_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (busy !== 1'b0 || req_pend !== '0 || done_cnt < 0) begin
            errors++;
            $display("FAIL rstmid_after busy=%b pend=%b required 0/0000", busy, req_pend);
        end
    endtask

    initial begin
        req_pulse = '0;
        err_clr   = 1'b0;
        ack_en    = 1'b1;
        test_reset();
        test_fairness();
        test_rotation();
        test_single();
        test_collision();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
